inst_fetch_responder: RTL
=========================

# inst_fetch_responder

Instruction-memory responder for the IF stage: the serving end of the fetch interface driven by the PC register (`pc` address plus `ce` chip enable). Accepts one word-fetch request per cycle with no back-pressure, reads a word-addressed instruction store, and returns the instruction through a fixed-latency pipeline tagged with its address. It also provides a program-load write port for boot and test, and flags misaligned or out-of-range fetches.

## Interface
- `LATENCY`, 1: request-to-response latency in cycles; legal range 1..4.
- `ADDR_WIDTH_W`, 10: log2 of store depth in 32-bit words (default 1024 words).
- `FAULT_INST`, 32'h00000013: word returned on a faulting fetch (NOP).
- `clk`  input  1  system clock; everything updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `ce`  input  1  fetch request valid; `ChipEnable` = request, `ChipDisable` = idle.
- `addr`  input  `InstAddrBus` (32)  byte address of the fetch.
- `ld_en`  input  1  program-load write enable.
- `ld_addr`  input  `ADDR_WIDTH_W`  word index to write.
- `ld_data`  input  32  word to write.
- `inst`  output  32  returned instruction.
- `inst_addr`  output  32  byte address the current `inst` belongs to.
- `inst_valid`  output  1  `inst` and `inst_addr` are valid this cycle.
- `fetch_fault`  output  1  the response is a fault; `inst` = `FAULT_INST`.
- `fetch_count`  output  32  number of responses delivered since reset; saturates at 32'hFFFFFFFF.

## Operation
- Request acceptance: every rising edge with `ce`=`ChipEnable` and `rst`=0 accepts a request. There is no stall or ready signal, so the responder sustains one request per cycle indefinitely.
- Decode: word index = `addr[ADDR_WIDTH_W+1:2]`.
  - Misaligned: `addr[1:0]` != 0.
  - Out of range: any bit of `addr[31:ADDR_WIDTH_W+2]` set.
  - Either condition gives a fault: no array read, data = `FAULT_INST`.
- Pipeline: a `LATENCY`-deep register chain carries {valid, addr, data, fault}.
  - Stage 0 captures the request and the array read.
  - The last stage drives the outputs.
  - An idle cycle (`ce` low) inserts a bubble (valid=0); bubbles propagate like requests.
- Load port: `ld_en`=1 writes `ld_data` to `mem[ld_addr]` at the edge.
  - A fetch of the same word on the same edge returns the old contents (read-before-write).
  - The new value is visible to a fetch on the following edge.
- Store contents are not cleared by `rst`; they are initialised to `FAULT_INST` at elaboration.
- `fetch_count` increments by 1 on each edge where the last stage becomes valid, whether the response faults or not. It holds once it saturates.
- Outputs while `inst_valid`=0: `inst`=`ZeroWord`, `inst_addr`=`ZeroWord`, `fetch_fault`=0.

## Timing
- Reset: on an edge with `rst`=1:
  - all pipeline valid bits clear;
  - `inst_valid`=0, `inst`=0, `inst_addr`=0, `fetch_fault`=0, `fetch_count`=0;
  - any request presented on that edge is dropped, and in-flight requests are discarded.
- Latency: a request sampled at edge k gives `inst_valid`=1 after edge k+LATENCY-1, lasting exactly one cycle.
  - With `LATENCY`=1, the response is visible in the cycle immediately following the sampling edge.
- Back-to-back requests produce back-to-back responses in request order, with no gaps and no reordering.
- Mid-flight reset: when `rst` deasserts, the first valid response appears LATENCY edges after the first accepted request. No stale response may appear.
- The load port takes effect in one cycle, independent of `LATENCY`.

## Test plan
- Sequential fetch, `LATENCY`=1:
  - Stimulus: preload words 0..3 = 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444; hold `ce`=1 with `addr` = 0, 4, 8, 12 on consecutive edges.
  - Response: `inst` shows the four words on four consecutive cycles, `inst_addr` = 0, 4, 8, 12, and `fetch_count` = 4.
- Bubbles, `LATENCY`=3:
  - Stimulus: requests to 0 and 4 with one `ce`=0 cycle between them.
  - Response: valid pulses appear 3 edges after each request, separated by one invalid cycle.
- Faults:
  - Stimulus: `addr`=32'h00000002, then `addr`=32'h00001000 (beyond the 1024-word store).
  - Response: both return `inst`=32'h00000013 with `fetch_fault`=1, and `fetch_count` increments for each.
- Load hazard:
  - Stimulus: on the same edge, `ld_en`=1, `ld_addr`=5, `ld_data`=32'hDEADBEEF, and a fetch of `addr`=20; fetch `addr`=20 again on the next edge.
  - Response: the first fetch returns the old word; the second returns 32'hDEADBEEF.
- Reset mid-flight, `LATENCY`=4:
  - Stimulus: issue 3 requests, then pulse `rst` for 1 cycle.
  - Response: no `inst_valid` appears for the pre-reset requests, all outputs read 0, and `fetch_count`=0.
- Counter saturation:
  - Stimulus: force `fetch_count` to 32'hFFFFFFFE, then issue 3 requests.
  - Response: the count reads 32'hFFFFFFFF and holds.

Source files
------------

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: fixed-latency instruction-store responder for the IF stage
// Ports: clk, rst (sync, active-high); ce + addr = one fetch request per cycle;
//        ld_en/ld_addr/ld_data = program-load write port;
//        inst/inst_addr/inst_valid/fetch_fault = tagged response; fetch_count = saturating response count.
module inst_fetch_responder #(
   parameter int          LATENCY      = 1,
   parameter int          ADDR_WIDTH_W = 10,
   parameter logic [31:0] FAULT_INST   = 32'h00000013
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ce,
   input  logic [31:0]             addr,
   input  logic                    ld_en,
   input  logic [ADDR_WIDTH_W-1:0] ld_addr,
   input  logic [31:0]             ld_data,
   output logic [31:0]             inst,
   output logic [31:0]             inst_addr,
   output logic                    inst_valid,
   output logic                    fetch_fault,
   output logic [31:0]             fetch_count
);
   logic [31:0]        mem [1 << ADDR_WIDTH_W] = '{default: FAULT_INST};
   logic [LATENCY-1:0] vld;
   logic [LATENCY-1:0] flt;
   logic [LATENCY-1:0] vld_next;
   logic [31:0]        adr [LATENCY];
   logic [31:0]        dat [LATENCY];
   logic [31:0]        count;
   logic               fault;
   assign fault = (addr[1:0] != 2'b0) || (addr[31:ADDR_WIDTH_W+2] != '0);
   // Shift a new valid bit in at stage 0; the cast drops the bit leaving the last stage.
   assign vld_next = rst ? '0 : LATENCY'({vld, ce});
   // Reads sample the pre-edge contents, so a same-edge load is seen only by later fetches.
   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
   end
   always_ff @(posedge clk) begin
      vld    <= vld_next;
      flt    <= LATENCY'({flt, fault});
      adr[0] <= addr;
      dat[0] <= fault ? FAULT_INST : mem[addr[ADDR_WIDTH_W+1:2]];
      for (int i = 1; i < LATENCY; i++) begin
         adr[i] <= adr[i-1];
         dat[i] <= dat[i-1];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) count <= '0;
      else if (vld_next[LATENCY-1] && ~&count) count <= count + 32'd1;
   end
   assign inst_valid  = vld[LATENCY-1];
   assign inst        = inst_valid ? dat[LATENCY-1] : 32'h0;
   assign inst_addr   = inst_valid ? adr[LATENCY-1] : 32'h0;
   assign fetch_fault = inst_valid & flt[LATENCY-1];
   assign fetch_count = count;
endmodule
